// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and helpers for the 3x1 conv frame sequencer
// Frame phases, kernel tap select codes and counter sizing.

package conv_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PAD_TOP,
      STREAM,
      PAD_BOT,
      DRAIN,
      DONE
   } state_t;

   localparam logic [1:0] TAP_SEL_00 = 2'd0;
   localparam logic [1:0] TAP_SEL_03 = 2'd1;
   localparam logic [1:0] TAP_SEL_06 = 2'd2;

   // Wide enough for every pixel of a padded frame: D*(D+2).
   function automatic int cnt_width(input int d);
      return $clog2(d * (d + 2) + 1);
   endfunction

endpackage

// File: rtl/conv_seq_tap_regs.sv
// rtl/conv_seq_tap_regs.sv - three kernel tap registers, writable only while the sequencer is idle
// Taps stay frozen for the whole frame; sel 3 is ignored.

module conv_seq_tap_regs
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  idle,
   input  logic                  k_wr_en,
   input  logic [1:0]            k_wr_sel,
   input  logic [DATA_WIDTH-1:0] k_wr_data,
   output logic [DATA_WIDTH-1:0] kernel_00,
   output logic [DATA_WIDTH-1:0] kernel_03,
   output logic [DATA_WIDTH-1:0] kernel_06
);

   always_ff @(posedge clk) begin
      if (reset) begin
         kernel_00 <= '0;
         kernel_03 <= '0;
         kernel_06 <= '0;
      end else if (k_wr_en && idle) begin
         case (k_wr_sel)
            TAP_SEL_00: kernel_00 <= k_wr_data;
            TAP_SEL_03: kernel_03 <= k_wr_data;
            TAP_SEL_06: kernel_06 <= k_wr_data;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/conv_31_seq_ctrl.sv
// rtl/conv_31_seq_ctrl.sv - 3x1 conv frame sequencer: taps, zero-padded pixel stream, output count
// Optional DRAIN watchdog with sticky err output when CONV_SEQ_WDOG_EN is defined.

module conv_31_seq_ctrl
   import conv_pkg::*;
#(
   parameter int D          = 220,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     k_wr_en,
   input  logic [1:0]               k_wr_sel,
   input  logic [DATA_WIDTH-1:0]    k_wr_data,
   output logic [DATA_WIDTH-1:0]    kernel_00,
   output logic [DATA_WIDTH-1:0]    kernel_03,
   output logic [DATA_WIDTH-1:0]    kernel_06,
   output logic                     mem_rd_en,
   output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
   input  logic [DATA_WIDTH-1:0]    mem_rd_data,
   output logic [DATA_WIDTH-1:0]    pxl_out,
   output logic                     pxl_valid,
   input  logic                     conv_valid,
   output logic [$clog2(D*D+1)-1:0] out_count
`ifdef CONV_SEQ_WDOG_EN
   ,
   output logic                     err
`endif
);

   localparam int CW  = cnt_width(D);
   localparam int OCW = $clog2(D * D + 1);

   localparam logic [CW-1:0]         PAD_LAST   = CW'(D - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(D * D - 1);
   localparam logic [OCW-1:0]        FRAME_OUTS = OCW'(D * D);
`ifdef CONV_SEQ_WDOG_EN
   localparam logic [23:0]           WD_LAST    = 24'(2 * D * D - 1);
`endif

   state_t        state;
   logic [CW-1:0] pad_cnt;
   logic          pad_s;
   logic          rd_en_q;
   logic          pad_q;
   logic          idle;
`ifdef CONV_SEQ_WDOG_EN
   logic [23:0]   wd_cnt;
`endif

   assign idle = (state == IDLE);

   conv_seq_tap_regs #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_taps (
      .clk       (clk),
      .reset     (reset),
      .idle      (idle),
      .k_wr_en   (k_wr_en),
      .k_wr_sel  (k_wr_sel),
      .k_wr_data (k_wr_data),
      .kernel_00 (kernel_00),
      .kernel_03 (kernel_03),
      .kernel_06 (kernel_06)
   );

   // Each FSM cycle in PAD_TOP/STREAM/PAD_BOT issues exactly one pixel slot (pad_s or mem_rd_en);
   // the slot reaches pxl_out two cycles later, so the padded frame leaves without gaps.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         pad_cnt     <= '0;
         pad_s       <= 1'b0;
         mem_rd_en   <= 1'b0;
         mem_rd_addr <= '0;
         out_count   <= '0;
`ifdef CONV_SEQ_WDOG_EN
         wd_cnt      <= '0;
         err         <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state   <= PAD_TOP;
                  busy    <= 1'b1;
                  pad_cnt <= '0;
                  pad_s   <= 1'b1;
`ifdef CONV_SEQ_WDOG_EN
                  err     <= 1'b0;
`endif
               end
            end
            PAD_TOP: begin
               if (pad_cnt == PAD_LAST) begin
                  state       <= STREAM;
                  pad_s       <= 1'b0;
                  mem_rd_en   <= 1'b1;
                  mem_rd_addr <= '0;
               end else begin
                  pad_cnt <= pad_cnt + 1'b1;
               end
            end
            STREAM: begin
               if (mem_rd_addr == LAST_ADDR) begin
                  state     <= PAD_BOT;
                  mem_rd_en <= 1'b0;
                  pad_s     <= 1'b1;
                  pad_cnt   <= '0;
               end else begin
                  mem_rd_addr <= mem_rd_addr + 1'b1;
               end
            end
            PAD_BOT: begin
               if (pad_cnt == PAD_LAST) begin
                  state <= DRAIN;
                  pad_s <= 1'b0;
`ifdef CONV_SEQ_WDOG_EN
                  wd_cnt <= '0;
`endif
               end else begin
                  pad_cnt <= pad_cnt + 1'b1;
               end
            end
            DRAIN: begin
               if (out_count == FRAME_OUTS) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end
`ifdef CONV_SEQ_WDOG_EN
               else if (wd_cnt == WD_LAST) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  err   <= 1'b1;
               end else begin
                  wd_cnt <= wd_cnt + 1'b1;
               end
`endif
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         if (idle && start) begin
            out_count <= '0;
         end else if (busy && conv_valid && (out_count != FRAME_OUTS)) begin
            out_count <= out_count + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_en_q   <= 1'b0;
         pad_q     <= 1'b0;
         pxl_valid <= 1'b0;
         pxl_out   <= '0;
      end else begin
         rd_en_q   <= mem_rd_en;
         pad_q     <= pad_s;
         pxl_valid <= rd_en_q | pad_q;
         pxl_out   <= rd_en_q ? mem_rd_data : '0;
      end
   end

endmodule

// File: tb/tb_conv_31_seq_ctrl.sv
// tb/tb_conv_31_seq_ctrl.sv - scoreboard bench for conv_31_seq_ctrl at D=4
// Watchdog scenario is included when CONV_SEQ_WDOG_EN is defined.

module tb_conv_31_seq_ctrl;

   localparam int D  = 4;
   localparam int DW = 32;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          k_wr_en = 1'b0;
   logic [1:0]    k_wr_sel = 2'd0;
   logic [DW-1:0] k_wr_data = '0;
   logic [DW-1:0] kernel_00;
   logic [DW-1:0] kernel_03;
   logic [DW-1:0] kernel_06;
   logic          mem_rd_en;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0;
   logic [DW-1:0] pxl_out;
   logic          pxl_valid;
   logic          conv_valid = 1'b0;
   logic [4:0]    out_count;
`ifdef CONV_SEQ_WDOG_EN
   logic          err;
`endif

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] exp_q[$];

   conv_31_seq_ctrl #(
      .D          (D),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .k_wr_en     (k_wr_en),
      .k_wr_sel    (k_wr_sel),
      .k_wr_data   (k_wr_data),
      .kernel_00   (kernel_00),
      .kernel_03   (kernel_03),
      .kernel_06   (kernel_06),
      .mem_rd_en   (mem_rd_en),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .pxl_out     (pxl_out),
      .pxl_valid   (pxl_valid),
      .conv_valid  (conv_valid),
`ifdef CONV_SEQ_WDOG_EN
      .err         (err),
`endif
      .out_count   (out_count)
   );

   always #5 clk = ~clk;

   // Pixel RAM: data one cycle after the read strobe, garbage otherwise.
   always @(posedge clk) begin
      mem_rd_data <= mem_rd_en ? (DW'(mem_rd_addr) + 32'd100) : 32'hDEAD_BEEF;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_frame(input bit wr, input logic [1:0] sel, input logic [DW-1:0] data, input bit push);
      if (push) begin
         for (int i = 0; i < D; i++) exp_q.push_back('0);
         for (int a = 0; a < D * D; a++) exp_q.push_back(DW'(a + 100));
         for (int i = 0; i < D; i++) exp_q.push_back('0);
      end
      start = 1'b1;
      k_wr_en = wr;
      k_wr_sel = sel;
      k_wr_data = data;
      tick();
      start = 1'b0;
      k_wr_en = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b expected 1", busy);
      end
   endtask

   task automatic stream_frame(input string tag);
      int n;
      int waits;
      logic [DW-1:0] e;
      n = 0;
      waits = 0;
      while (!pxl_valid && waits < 20) begin
         tick();
         waits++;
      end
      while (pxl_valid && n < 100) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_extra_pixel: got %0d with nothing expected", tag, pxl_out);
         end else begin
            e = exp_q.pop_front();
            if (pxl_out !== e) begin
               errors++;
               $display("FAIL %s_pixel[%0d]: got %0d expected %0d", tag, n, pxl_out, e);
            end
         end
         n++;
         tick();
      end
      checks++;
      if (n != D * (D + 2)) begin
         errors++;
         $display("FAIL %s_run_length: got %0d expected %0d", tag, n, D * (D + 2));
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_leftover: got %0d pending expected 0", tag, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic finish_frame(input int pulses, input bit start_at_done, input int exp_count, output int waited);
      bit seen;
      seen = 1'b0;
      waited = -1;
      for (int i = 0; i < 80 && !seen; i++) begin
         conv_valid = (i < pulses);
         tick();
         waited = i;
         if (done) seen = 1'b1;
      end
      conv_valid = 1'b0;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL done_timeout: got no done expected done within 80 cycles");
      end else begin
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b expected 0", busy);
         end
         checks++;
         if (out_count !== 5'(exp_count)) begin
            errors++;
            $display("FAIL out_count_at_done: got %0d expected %0d", out_count, exp_count);
         end
      end
      start = start_at_done;
      tick();
      start = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) tick();
      checks++;
      if ({busy, done, pxl_valid, mem_rd_en} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 0000", {busy, done, pxl_valid, mem_rd_en});
      end
      checks++;
      if (out_count !== '0 || mem_rd_addr !== '0 || pxl_out !== '0) begin
         errors++;
         $display("FAIL reset_values: got cnt=%0d addr=%0d pxl=%0d expected 0", out_count, mem_rd_addr, pxl_out);
      end
      checks++;
      if ({kernel_00, kernel_03, kernel_06} !== '0) begin
         errors++;
         $display("FAIL reset_taps: got %0d %0d %0d expected 0 0 0", kernel_00, kernel_03, kernel_06);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_taps;
      for (int s = 0; s < 4; s++) begin
         k_wr_en = 1'b1;
         k_wr_sel = 2'(s);
         k_wr_data = (s == 3) ? 32'd77 : DW'(s + 1);
         tick();
      end
      k_wr_en = 1'b0;
      checks++;
      if (kernel_00 !== 32'd1 || kernel_03 !== 32'd2 || kernel_06 !== 32'd3) begin
         errors++;
         $display("FAIL taps_write: got %0d %0d %0d expected 1 2 3", kernel_00, kernel_03, kernel_06);
      end
   endtask

   task automatic test_frame;
      int w;
      start_frame(1'b0, 2'd0, '0, 1'b1);
      stream_frame("frame");
      finish_frame(16, 1'b0, 16, w);
   endtask

   task automatic test_busy_write;
      int w;
      start_frame(1'b0, 2'd0, '0, 1'b1);
      k_wr_en = 1'b1;
      k_wr_sel = 2'd0;
      k_wr_data = 32'd9;
      start = 1'b1;
      tick();
      k_wr_en = 1'b0;
      start = 1'b0;
      checks++;
      if (kernel_00 !== 32'd1) begin
         errors++;
         $display("FAIL tap_write_busy: got %0d expected 1", kernel_00);
      end
      stream_frame("busy");
      checks++;
      if (kernel_00 !== 32'd1) begin
         errors++;
         $display("FAIL tap_stable_frame: got %0d expected 1", kernel_00);
      end
      finish_frame(16, 1'b1, 16, w);
      repeat (3) tick();
      checks++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL start_at_done_ignored: got busy=%b rd_en=%b expected 0 0", busy, mem_rd_en);
      end
      k_wr_en = 1'b1;
      tick();
      k_wr_en = 1'b0;
      checks++;
      if (kernel_00 !== 32'd9) begin
         errors++;
         $display("FAIL tap_write_idle: got %0d expected 9", kernel_00);
      end
   endtask

   task automatic test_start_write;
      int w;
      start_frame(1'b1, 2'd1, 32'd5, 1'b1);
      checks++;
      if (kernel_03 !== 32'd5) begin
         errors++;
         $display("FAIL tap_write_at_start: got %0d expected 5", kernel_03);
      end
      stream_frame("satur");
      finish_frame(20, 1'b0, 16, w);
      conv_valid = 1'b1;
      repeat (3) tick();
      conv_valid = 1'b0;
      checks++;
      if (out_count !== 5'd16) begin
         errors++;
         $display("FAIL conv_valid_idle: got %0d expected 16", out_count);
      end
   endtask

`ifdef CONV_SEQ_WDOG_EN
   task automatic test_wdog;
      int w;
      start_frame(1'b0, 2'd0, '0, 1'b1);
      stream_frame("wdog");
      finish_frame(0, 1'b0, 0, w);
      checks++;
      if (w != 29) begin
         errors++;
         $display("FAIL wdog_latency: got %0d expected 29", w);
      end
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL wdog_err_set: got %b expected 1", err);
      end
      start_frame(1'b0, 2'd0, '0, 1'b1);
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL wdog_err_clear: got %b expected 0", err);
      end
      stream_frame("wdog2");
      finish_frame(16, 1'b0, 16, w);
   endtask
`endif

   task automatic test_reset_mid;
      bit hit;
      bit saw_done;
      hit = 1'b0;
      saw_done = 1'b0;
      start_frame(1'b0, 2'd0, '0, 1'b0);
      for (int i = 0; i < 40 && !hit; i++) begin
         if (mem_rd_en && mem_rd_addr == 16'd7) hit = 1'b1;
         else tick();
      end
      checks++;
      if (!hit) begin
         errors++;
         $display("FAIL reset_mid_reach: got no read of addr 7 expected one");
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++;
      if (busy !== 1'b0 || pxl_valid !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_flags: got busy=%b valid=%b done=%b expected 0 0 0", busy, pxl_valid, done);
      end
      checks++;
      if ({kernel_00, kernel_03, kernel_06} !== '0) begin
         errors++;
         $display("FAIL reset_mid_taps: got %0d %0d %0d expected 0 0 0", kernel_00, kernel_03, kernel_06);
      end
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done || pxl_valid) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         errors++;
         $display("FAIL reset_mid_quiet: got done/pixel activity expected none");
      end
   endtask

   initial begin
      test_reset();
      test_taps();
      test_frame();
      test_busy_write();
      test_start_write();
`ifdef CONV_SEQ_WDOG_EN
      test_wdog();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
